// File: rtl/led_matrix_pkg.sv
// Shared sizing helpers for the PWM LED matrix scanner: slot length, pixel
// bit placement inside the frame buffer, and counter widths.
package led_matrix_pkg;

  function automatic int slot_len(input int blank, input int bpp, input int step);
    return blank + ((1 << bpp) - 1) * step;
  endfunction

  // Pixel (c, r) occupies BPP bits starting at this index of the frame buffer.
  function automatic int pix_base(input int c, input int r, input int rows, input int bpp);
    return (c * rows + r) * bpp;
  endfunction

  function automatic int cnt_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

  function automatic int t_width(input int blank, input int bpp, input int step);
    return cnt_width(slot_len(blank, bpp, step));
  endfunction

  function automatic int col_width(input int cols);
    return cnt_width(cols);
  endfunction

  function automatic int step_width(input int step);
    return cnt_width(step);
  endfunction

endpackage

// File: rtl/led_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin, with a rising-edge pulse
// taken from the synchronised value.
module led_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_sync,
  output logic o_rise
);

  logic r_meta;
  logic r_sync;
  logic r_prev;

  // synchroniser chain plus one history flop for edge detection
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_meta <= 1'b0;
      r_sync <= 1'b0;
      r_prev <= 1'b0;
    end else begin
      r_meta <= i_async;
      r_sync <= r_meta;
      r_prev <= r_sync;
    end
  end

  assign o_sync = r_sync;
  assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/led_matrix_pwm_scanner.sv
// Column-scanned LED matrix driver with per-pixel PWM brightness, serial
// pixel loading and a tear-free double-buffered frame store.
module led_matrix_pwm_scanner
  import led_matrix_pkg::*;
#(
  parameter int ROWS  = 8,
  parameter int COLS  = 8,
  parameter int BPP   = 2,
  parameter int STEP  = 4,
  parameter int BLANK = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            ena,
  input  logic            din,
  input  logic            dclk,
  input  logic            strobe,
  output logic [ROWS-1:0] row_out,
  output logic [COLS-1:0] col_sel,
  output logic            frame_start
);

  localparam int N  = ROWS * COLS * BPP;
  localparam int L  = slot_len(BLANK, BPP, STEP);
  localparam int TW = t_width(BLANK, BPP, STEP);
  localparam int CW = col_width(COLS);
  localparam int SW = step_width(STEP);

  localparam logic [TW-1:0] T_LAST  = TW'(L - 1);
  localparam logic [TW-1:0] T_BLANK = TW'(BLANK);
  localparam logic [CW-1:0] C_LAST  = CW'(COLS - 1);
  localparam logic [SW-1:0] S_LAST  = SW'(STEP - 1);

  logic           r_din_meta;
  logic           r_din_sync;
  logic           w_dclk_sync;
  logic           w_dclk_rise;
  logic           w_strobe_sync;
  logic           w_strobe_rise;

  logic [N-1:0]   r_sr;
  logic [N-1:0]   r_shadow;
  logic [N-1:0]   r_display;
  logic           r_pending;

  logic [TW-1:0]  r_t;
  logic [CW-1:0]  r_col;
  logic [SW-1:0]  r_step;
  logic [BPP-1:0] r_lvl;

  logic           w_frame_edge;
  logic [ROWS-1:0] w_row_nx;
  logic [COLS-1:0] w_col_nx;
  logic           w_fs_nx;

  led_sync_edge u_dclk_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (dclk),
    .o_sync  (w_dclk_sync),
    .o_rise  (w_dclk_rise)
  );

  led_sync_edge u_strobe_sync (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_async (strobe),
    .o_sync  (w_strobe_sync),
    .o_rise  (w_strobe_rise)
  );

  // din gets the same two-flop delay as dclk so the pair stays aligned
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_din_meta <= 1'b0;
      r_din_sync <= 1'b0;
    end else begin
      r_din_meta <= din;
      r_din_sync <= r_din_meta;
    end
  end

  assign w_frame_edge = ena & (r_t == '0) & (r_col == '0);

  // shift register, shadow latch and frame-boundary swap into the display buffer
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_sr      <= '0;
      r_shadow  <= '0;
      r_display <= '0;
      r_pending <= 1'b0;
    end else begin
      if (w_dclk_rise) begin
        r_sr <= {r_sr[N-2:0], r_din_sync};
      end
      if (w_frame_edge && r_pending) begin
        r_display <= r_shadow;
      end
      // a strobe coinciding with the swap keeps pending so the new data shows next frame
      if (w_strobe_rise) begin
        r_shadow  <= r_sr;
        r_pending <= 1'b1;
      end else if (w_frame_edge) begin
        r_pending <= 1'b0;
      end
    end
  end

  // slot time, column, and step/level sub-counters that replace a divider
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_t    <= '0;
      r_col  <= '0;
      r_step <= '0;
      r_lvl  <= '0;
    end else if (ena) begin
      if (r_t == T_LAST) begin
        r_t    <= '0;
        r_step <= '0;
        r_lvl  <= '0;
        r_col  <= (r_col == C_LAST) ? '0 : r_col + CW'(1);
      end else begin
        r_t <= r_t + TW'(1);
        if (r_t >= T_BLANK) begin
          if (r_step == S_LAST) begin
            r_step <= '0;
            r_lvl  <= r_lvl + BPP'(1);
          end else begin
            r_step <= r_step + SW'(1);
          end
        end
      end
    end
  end

  // next output values from the pre-edge slot position
  always_comb begin
    w_row_nx = '0;
    w_col_nx = '0;
    w_fs_nx  = w_frame_edge;
    if (ena && (r_t >= T_BLANK)) begin
      w_col_nx = COLS'(1'b1) << r_col;
      for (int r = 0; r < ROWS; r++) begin
        w_row_nx[r] = r_display[pix_base(int'(r_col), r, ROWS, BPP) +: BPP] > r_lvl;
      end
    end else begin
      w_row_nx = '0;
      w_col_nx = '0;
    end
  end

  // registered outputs
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      row_out     <= '0;
      col_sel     <= '0;
      frame_start <= 1'b0;
    end else begin
      row_out     <= w_row_nx;
      col_sel     <= w_col_nx;
      frame_start <= w_fs_nx;
    end
  end

  logic w_unused;
  assign w_unused = w_dclk_sync ^ w_strobe_sync;

endmodule

// File: tb/tb_led_matrix_pwm_scanner.sv
// Directed self-checking bench for led_matrix_pwm_scanner at default parameters.
module tb_led_matrix_pwm_scanner;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       ena;
  logic       din;
  logic       dclk;
  logic       strobe;
  logic [7:0] row_out;
  logic [7:0] col_sel;
  logic       frame_start;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc;
  int n;

  localparam logic [127:0] IMG_ONES = {128{1'b1}};
  localparam logic [127:0] IMG_GRAY = 128'hE4E4;
  localparam logic [127:0] IMG_ZERO = 128'h0;

  led_matrix_pwm_scanner dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ena         (ena),
    .din         (din),
    .dclk        (dclk),
    .strobe      (strobe),
    .row_out     (row_out),
    .col_sel     (col_sel),
    .frame_start (frame_start)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
  endtask

  task automatic shift_bit(input logic b);
    din = b;
    repeat (4) @(negedge clk);
    dclk = 1'b1;
    repeat (4) @(negedge clk);
    dclk = 1'b0;
  endtask

  task automatic load_image(input logic [127:0] img);
    for (int i = 127; i >= 0; i--) shift_bit(img[i]);
  endtask

  task automatic pulse_strobe();
    strobe = 1'b1;
    repeat (4) @(negedge clk);
    strobe = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic wait_fs(output int cnt, input string tag);
    logic found;
    found = 1'b0;
    cnt = 0;
    while (cnt < 400 && !found) begin
      @(negedge clk);
      cnt++;
      if (frame_start) found = 1'b1;
    end
    check({tag, "_fs_found"}, found, 1'b1);
  endtask

  // Called at the negedge that shows frame_start; walks one full 112-clock frame.
  task automatic run_frame(input logic [127:0] img, input string tag);
    for (int j = 0; j < 112; j++) begin
      int c;
      int t;
      logic [7:0] er;
      logic [7:0] ec;
      c  = j / 14;
      t  = j % 14;
      er = 8'h00;
      ec = 8'h00;
      if (t >= 2) begin
        ec = 8'h01 << c;
        for (int r = 0; r < 8; r++) begin
          if (int'(img[(c * 8 + r) * 2 +: 2]) > (t - 2) / 4) er[r] = 1'b1;
        end
      end
      check({tag, "_row"}, row_out, er);
      check({tag, "_col"}, col_sel, ec);
      check({tag, "_fs"}, frame_start, (j == 0));
      check({tag, "_onehot"}, ($countones(col_sel) <= 1), 1'b1);
      @(negedge clk);
    end
  endtask

  initial begin
    rst_n = 1'b0; ena = 1'b1; din = 1'b0; dclk = 1'b0; strobe = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_row", row_out, 8'h00);
    check("rst_col", col_sel, 8'h00);
    check("rst_fs", frame_start, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check("first_fs", frame_start, 1'b1);
    check("first_blank_col", col_sel, 8'h00);
    wait_fs(n, "period");
    check("period_112", n, 112);

    // full-on image
    load_image(IMG_ONES);
    pulse_strobe();
    wait_fs(n, "full");
    run_frame(IMG_ONES, "full");

    // gray levels in column 0
    load_image(IMG_GRAY);
    pulse_strobe();
    wait_fs(n, "gray");
    run_frame(IMG_GRAY, "gray");
    repeat (2) @(negedge clk);
    check("gray_k0_row", row_out, 8'hEE);
    check("gray_k0_col", col_sel, 8'h01);
    repeat (4) @(negedge clk);
    check("gray_k1_row", row_out, 8'hCC);
    repeat (4) @(negedge clk);
    check("gray_k2_row", row_out, 8'h88);
    repeat (4) @(negedge clk);
    check("gray_c1_blank", col_sel, 8'h00);
    repeat (2) @(negedge clk);
    check("gray_c1_col", col_sel, 8'h02);
    check("gray_c1_row", row_out, 8'h00);

    // strobe mid-frame: current frame keeps the old image
    load_image(IMG_ONES);
    wait_fs(n, "mid");
    repeat (30) @(negedge clk);
    pulse_strobe();
    repeat (6) @(negedge clk);
    check("mid_old_row", row_out, 8'h00);
    check("mid_old_col", col_sel, 8'h08);
    wait_fs(n, "mid_next");
    run_frame(IMG_ONES, "mid_new");

    // strobe rising exactly on the frame-start edge
    load_image(IMG_GRAY);
    wait_fs(n, "edge");
    repeat (109) @(negedge clk);
    strobe = 1'b1;
    repeat (3) @(negedge clk);
    check("edge_fs", frame_start, 1'b1);
    strobe = 1'b0;
    run_frame(IMG_ONES, "edge_old");
    run_frame(IMG_GRAY, "edge_new");

    // enable gating for 20 clocks at t=5 of column 0
    cyc = 0;
    repeat (5) step();
    ena = 1'b0;
    step();
    check("ena_off_row", row_out, 8'h00);
    check("ena_off_col", col_sel, 8'h00);
    repeat (19) step();
    check("ena_off_row_end", row_out, 8'h00);
    ena = 1'b1;
    step();
    check("ena_resume_row", row_out, 8'hCC);
    check("ena_resume_col", col_sel, 8'h01);
    repeat (4) step();
    check("ena_resume_k2", row_out, 8'h88);
    wait_fs(n, "ena");
    check("ena_period_132", cyc + n, 132);

    // reset asserted mid-frame
    repeat (2) @(negedge clk);
    check("prerst_row", row_out, 8'hEE);
    check("prerst_col", col_sel, 8'h01);
    rst_n = 1'b0;
    @(negedge clk);
    check("midrst_row", row_out, 8'h00);
    check("midrst_col", col_sel, 8'h00);
    check("midrst_fs", frame_start, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_frame(IMG_ZERO, "postrst");
    check("postrst_next_fs", frame_start, 1'b1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
